// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Purpose  : I2C target with a 16-byte register file that is shared with a
//            CPU-side valid/ready bus. SCL/SDA are synchronised, edge
//            detected and decoded by a bit-level FSM. SDA is open-drain.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [23:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [3:0]  wstrb,
    input  logic        valid,
    output logic        ready,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    output logic        irq
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_ACK  = 4'd2,
        S_PTR       = 4'd3,
        S_PTR_ACK   = 4'd4,
        S_WDATA     = 4'd5,
        S_WDATA_ACK = 4'd6,
        S_RDATA     = 4'd7,
        S_RDATA_ACK = 4'd8,
        S_IGNORE    = 4'd9
    } state_t;

    localparam logic [4:0] c_STATUS_OFS = 5'h10;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_bitcnt, w_bitcnt_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [3:0]  r_ptr, w_ptr_nxt;
    logic        r_sda_oe, w_oe_nxt;
    logic        w_i2c_we;

    logic [7:0]  r_regs [16];
    logic        r_wr_event;
    logic        r_collision;
    logic        r_i2c_we_d;
    logic        r_ready;
    logic [31:0] r_read_data;

    logic        w_scl, w_sda;
    logic        w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]  w_rx_byte;
    logic [7:0]  w_ptr_byte;
    logic        w_busy;
    logic        w_cpu_acc, w_cpu_wr, w_cpu_reg_we, w_cpu_stat_we;
    logic [3:0]  w_cpu_idx;
    logic        w_collide;
    logic [7:0]  w_cpu_rdata;
    logic        w_unused_bits;

    // ------------------------------------------------------------------
    // Pin synchronisers plus one extra flop per line for edge detection;
    // reset to 1 so an idle bus produces no spurious edges.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise =  w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl &  r_scl_prev;
    assign w_start    = w_scl & r_scl_prev &  r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev &  w_sda;
    assign w_rx_byte  = {r_shift[6:0], w_sda};
    assign w_ptr_byte = r_regs[r_ptr];

    // ------------------------------------------------------------------
    // I2C protocol state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_bitcnt <= 4'd0;
            r_shift  <= 8'd0;
            r_ptr    <= 4'd0;
            r_sda_oe <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_ptr    <= w_ptr_nxt;
            r_sda_oe <= w_oe_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. In the *_ACK states of received bytes the current
    // SDA drive tells the first fall (assert ACK) from the second (release).
    // In RDATA_ACK, bitcnt==1 marks that the controller ACKed the byte.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_ptr_nxt    = r_ptr;
        w_oe_nxt     = r_sda_oe;
        w_i2c_we     = 1'b0;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_oe_nxt    = 1'b0;
        end else if (w_start) begin
            w_state_nxt  = S_ADDR;
            w_bitcnt_nxt = 4'd0;
            w_oe_nxt     = 1'b0;
        end else begin
            case (r_state)
                S_ADDR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_rx_byte;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_bitcnt_nxt = 4'd0;
                            w_state_nxt  = (w_rx_byte[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_bitcnt_nxt = 4'd0;
                            if (r_shift[0]) begin
                                w_state_nxt = S_RDATA;
                                w_shift_nxt = w_ptr_byte;
                                w_oe_nxt    = ~w_ptr_byte[7];
                            end else begin
                                w_state_nxt = S_PTR;
                                w_oe_nxt    = 1'b0;
                            end
                        end
                    end
                end
                S_PTR: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_rx_byte;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_ptr_nxt   = w_rx_byte[3:0];
                            w_state_nxt = S_PTR_ACK;
                        end
                    end
                end
                S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_rx_byte;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            w_i2c_we    = 1'b1;
                            w_ptr_nxt   = r_ptr + 4'd1;
                            w_state_nxt = S_WDATA_ACK;
                        end
                    end
                end
                S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (!r_sda_oe) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_oe_nxt     = 1'b0;
                            w_bitcnt_nxt = 4'd0;
                            w_state_nxt  = S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_oe_nxt     = 1'b0;
                            w_bitcnt_nxt = 4'd0;
                            w_state_nxt  = S_RDATA_ACK;
                        end else begin
                            w_oe_nxt    = ~r_shift[6];
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        w_ptr_nxt = r_ptr + 4'd1;
                        if (!w_sda) begin
                            w_bitcnt_nxt = 4'd1;
                        end else begin
                            w_state_nxt = S_IGNORE;
                        end
                    end else if (w_scl_fall && (r_bitcnt == 4'd1)) begin
                        w_bitcnt_nxt = 4'd0;
                        w_state_nxt  = S_RDATA;
                        w_shift_nxt  = w_ptr_byte;
                        w_oe_nxt     = ~w_ptr_byte[7];
                    end
                end
                S_IDLE, S_IGNORE: begin
                    w_state_nxt = r_state;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // CPU side decode
    // ------------------------------------------------------------------
    assign w_cpu_acc     = valid & ~r_ready;
    assign w_cpu_wr      = w_cpu_acc & wstrb[0];
    assign w_cpu_idx     = address[5:2];
    assign w_cpu_reg_we  = w_cpu_wr & ~address[6];
    assign w_cpu_stat_we = w_cpu_wr & (address[6:2] == c_STATUS_OFS);
    assign w_collide     = w_cpu_reg_we & w_i2c_we & (w_cpu_idx == r_ptr);
    assign w_busy        = (r_state != S_IDLE) && (r_state != S_IGNORE);

    // CPU read mux: register bytes, status, zero elsewhere
    always_comb begin
        w_cpu_rdata = 8'd0;
        if (!address[6]) begin
            w_cpu_rdata = r_regs[w_cpu_idx];
        end else if (address[6:2] == c_STATUS_OFS) begin
            w_cpu_rdata = {5'd0, r_collision, r_wr_event, w_busy};
        end
    end

    // Register file: the I2C write takes priority over a CPU write to the same byte
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 8'd0;
            end
        end else begin
            if (w_cpu_reg_we && !w_collide) begin
                r_regs[w_cpu_idx] <= write_data[7:0];
            end
            if (w_i2c_we) begin
                r_regs[r_ptr] <= w_rx_byte;
            end
        end
    end

    // Status flags: hardware set wins over a simultaneous write-1-to-clear
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_i2c_we_d  <= 1'b0;
            r_wr_event  <= 1'b0;
            r_collision <= 1'b0;
        end else begin
            r_i2c_we_d <= w_i2c_we;
            if (r_i2c_we_d) begin
                r_wr_event <= 1'b1;
            end else if (w_cpu_stat_we && write_data[1]) begin
                r_wr_event <= 1'b0;
            end
            if (w_collide) begin
                r_collision <= 1'b1;
            end else if (w_cpu_stat_we && write_data[2]) begin
                r_collision <= 1'b0;
            end
        end
    end

    // CPU handshake and registered read data
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ready     <= 1'b0;
            r_read_data <= 32'd0;
        end else begin
            r_ready <= w_cpu_acc;
            if (w_cpu_acc && !wstrb[0]) begin
                r_read_data <= {24'd0, w_cpu_rdata};
            end
        end
    end

    assign ready     = r_ready & valid;
    assign read_data = r_read_data;
    assign sda_oe    = r_sda_oe;
    assign irq       = r_wr_event;

    assign w_unused_bits = ^{address[23:7], address[1:0], write_data[31:8], wstrb[3:1]};

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_regs
// Purpose  : Self-checking bench for i2c_target_regs: directed scenarios plus
//            randomised I2C/CPU traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_regs;

    localparam int         Q     = 8;      // quarter SCL period in clocks
    localparam logic [6:0] TADDR = 7'h42;

    logic        clock      = 1'b0;
    logic        resetn     = 1'b0;
    logic [23:0] address    = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [3:0]  wstrb      = '0;
    logic        valid      = 1'b0;
    logic        ready;
    logic        sda_oe;
    logic        irq;
    logic        scl_drv    = 1'b1;
    logic        sda_drv    = 1'b1;
    logic        sda_line;

    int n_checks = 0;
    int n_fail   = 0;
    int oe_count = 0;

    // Transaction-level reference model
    logic [7:0] m_regs [16];
    int         m_ptr;
    logic       m_wr_event;
    logic       m_collision;
    logic [7:0] wq [$];

    assign sda_line = sda_drv & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(TADDR), .SYNC_STAGES(2)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .wstrb      (wstrb),
        .valid      (valid),
        .ready      (ready),
        .scl_i      (scl_drv),
        .sda_i      (sda_line),
        .sda_oe     (sda_oe),
        .irq        (irq)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (sda_oe) oe_count <= oe_count + 1;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr       = 0;
        m_wr_event  = 1'b0;
        m_collision = 1'b0;
    endtask

    function automatic logic [31:0] status_exp();
        return {29'd0, m_collision, m_wr_event, 1'b0};
    endfunction

    // One CPU access; ready must pulse for exactly one cycle while valid is held
    task automatic cpu_xfer(input logic [23:0] a, input logic wr, input logic [7:0] d,
                            output logic [31:0] rd);
        @(negedge clock);
        address    = a;
        wstrb      = wr ? 4'h1 : 4'h0;
        write_data = $urandom;
        write_data[7:0] = d;
        valid      = 1'b1;
        @(negedge clock);
        check("cpu_ready_pulse", {31'd0, ready}, 32'd1);
        rd = read_data;
        @(negedge clock);
        check("cpu_ready_single", {31'd0, ready}, 32'd0);
        valid = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic cpu_write(input logic [23:0] a, input logic [7:0] d);
        logic [31:0] rd;
        cpu_xfer(a, 1'b1, d, rd);
    endtask

    task automatic cpu_read(input string tag, input logic [23:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        cpu_xfer(a, 1'b0, 8'h00, rd);
        check(tag, rd, exp);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(Q);
    endtask

    // Controller writes a byte and samples the target's ACK. With collide set,
    // a CPU write to regs[2] is issued so it lands on the bit-8 commit edge.
    task automatic write_byte(input logic [7:0] b, input logic collide, input logic [7:0] cd,
                              output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i];
            tick(Q);
            scl_drv = 1'b1;
            if (collide && i == 0) begin
                tick(2);
                address    = 24'h000008;
                wstrb      = 4'h1;
                write_data = {24'h0, cd};
                valid      = 1'b1;
                @(negedge clock);
                check("coll_ready_pulse", {31'd0, ready}, 32'd1);
                @(negedge clock);
                check("coll_ready_single", {31'd0, ready}, 32'd0);
                valid = 1'b0;
                wstrb = 4'h0;
                tick(2*Q - 4);
            end else begin
                tick(2*Q);
            end
            scl_drv = 1'b0;
            tick(Q);
        end
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        acked = (sda_line == 1'b0);
        tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        sda_drv = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_drv = 1'b1; tick(Q);
            d[i] = sda_line;
            tick(Q);
            scl_drv = 1'b0; tick(Q);
        end
        sda_drv = nack; tick(Q);
        scl_drv = 1'b1; tick(2*Q);
        scl_drv = 1'b0; tick(Q);
        sda_drv = 1'b1;
    endtask

    // Full write transfer of the bytes queued in wq
    task automatic i2c_write_txn(input logic [7:0] ptr_byte);
        logic ack;
        i2c_start();
        write_byte({TADDR, 1'b0}, 1'b0, 8'h00, ack);
        check("wr_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(ptr_byte, 1'b0, 8'h00, ack);
        check("wr_ptr_ack", {31'd0, ack}, 32'd1);
        m_ptr = int'(ptr_byte[3:0]);
        foreach (wq[k]) begin
            write_byte(wq[k], 1'b0, 8'h00, ack);
            check("wr_data_ack", {31'd0, ack}, 32'd1);
            m_regs[m_ptr] = wq[k];
            m_ptr         = (m_ptr + 1) % 16;
            m_wr_event    = 1'b1;
        end
        i2c_stop();
    endtask

    // Read transfer of n bytes, optionally setting the pointer first via Sr
    task automatic i2c_read_txn(input logic set_ptr, input logic [7:0] ptr_byte, input int n);
        logic       ack;
        logic [7:0] d;
        i2c_start();
        if (set_ptr) begin
            write_byte({TADDR, 1'b0}, 1'b0, 8'h00, ack);
            check("rd_waddr_ack", {31'd0, ack}, 32'd1);
            write_byte(ptr_byte, 1'b0, 8'h00, ack);
            check("rd_ptr_ack", {31'd0, ack}, 32'd1);
            m_ptr = int'(ptr_byte[3:0]);
            i2c_start();
        end
        write_byte({TADDR, 1'b1}, 1'b0, 8'h00, ack);
        check("rd_addr_ack", {31'd0, ack}, 32'd1);
        for (int k = 0; k < n; k++) begin
            read_byte(k == n - 1, d);
            check("rd_data", {24'd0, d}, {24'd0, m_regs[m_ptr]});
            m_ptr = (m_ptr + 1) % 16;
        end
        i2c_stop();
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 16; i++) begin
            cpu_read("cpu_regdump", 24'(i * 4), {24'd0, m_regs[i]});
        end
    endtask

    initial begin
        logic       ack;
        int         base;
        logic [7:0] pb;
        model_reset();

        // Reset values
        tick(3);
        check("rst_read_data", read_data, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        resetn = 1'b1;
        tick(3);
        check("post_rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        cpu_read("rst_status", 24'h000040, status_exp());
        cpu_read("rst_reg0", 24'h000000, 32'd0);

        // Write with pointer wrap
        wq = '{8'hAA, 8'hBB};
        i2c_write_txn(8'h0E);
        tick(4);
        check("wr_irq", {31'd0, irq}, {31'd0, m_wr_event});
        cpu_read("cpu_rd_0x38", 24'h000038, 32'h0000_00AA);
        cpu_read("cpu_rd_0x3C", 24'h00003C, 32'h0000_00BB);
        i2c_read_txn(1'b0, 8'h00, 1);            // pointer wrapped to 0
        cpu_write(24'h000040, 8'h02);
        m_wr_event = 1'b0;
        tick(1);
        check("irq_cleared", {31'd0, irq}, 32'd0);

        // Repeated-START read
        cpu_write(24'h00000C, 8'h5A); m_regs[3] = 8'h5A;
        cpu_write(24'h000010, 8'hC3); m_regs[4] = 8'hC3;
        i2c_read_txn(1'b1, 8'h03, 2);
        cpu_read("status_after_read", 24'h000040, status_exp());

        // Address mismatch: no SDA drive, no change
        base = oe_count;
        i2c_start();
        write_byte(8'h90, 1'b0, 8'h00, ack);
        check("mismatch_nack_addr", {31'd0, ack}, 32'd0);
        write_byte(8'h01, 1'b0, 8'h00, ack);
        check("mismatch_nack_data", {31'd0, ack}, 32'd0);
        write_byte(8'hFF, 1'b0, 8'h00, ack);
        i2c_stop();
        check("mismatch_oe_never", oe_count - base, 32'd0);
        check("mismatch_irq", {31'd0, irq}, 32'd0);
        cpu_read("mismatch_reg1", 24'h000004, {24'd0, m_regs[1]});

        // Collision: I2C writes 0x11 while CPU writes 0x22 to regs[2]
        i2c_start();
        write_byte({TADDR, 1'b0}, 1'b0, 8'h00, ack);
        check("coll_addr_ack", {31'd0, ack}, 32'd1);
        write_byte(8'h02, 1'b0, 8'h00, ack);
        write_byte(8'h11, 1'b1, 8'h22, ack);
        check("coll_data_ack", {31'd0, ack}, 32'd1);
        i2c_stop();
        m_regs[2] = 8'h11; m_ptr = 3; m_wr_event = 1'b1; m_collision = 1'b1;
        cpu_read("coll_reg2", 24'h000008, 32'h0000_0011);
        cpu_read("coll_status", 24'h000040, status_exp());
        cpu_write(24'h000040, 8'h06);
        m_wr_event = 1'b0; m_collision = 1'b0;
        cpu_read("coll_status_clr", 24'h000040, status_exp());

        // Randomised traffic
        for (int it = 0; it < 6; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    wq.delete();
                    for (int k = 0; k < int'($urandom_range(1, 4)); k++) wq.push_back(8'($urandom));
                    pb = 8'($urandom);
                    i2c_write_txn(pb);
                    tick(4);
                    check("rnd_irq", {31'd0, irq}, {31'd0, m_wr_event});
                    cpu_write(24'h000040, 8'h02);
                    m_wr_event = 1'b0;
                end
                1: begin
                    pb = 8'($urandom);
                    i2c_read_txn($urandom_range(0, 3) != 0, pb, int'($urandom_range(1, 3)));
                end
                default: begin
                    base = int'($urandom_range(0, 15));
                    pb   = 8'($urandom);
                    cpu_write(24'(base * 4), pb);
                    m_regs[base] = pb;
                end
            endcase
        end
        check_all_regs();

        // Reset in the middle of a read while SDA is driven low
        cpu_write(24'h000014, 8'h00); m_regs[5] = 8'h00;
        i2c_start();
        write_byte({TADDR, 1'b0}, 1'b0, 8'h00, ack);
        write_byte(8'h05, 1'b0, 8'h00, ack);
        i2c_start();
        write_byte({TADDR, 1'b1}, 1'b0, 8'h00, ack);
        check("midrd_oe_driven", {31'd0, sda_oe}, 32'd1);
        #3 resetn = 1'b0;
        #1 check("midrd_oe_released", {31'd0, sda_oe}, 32'd0);
        model_reset();
        tick(3);
        resetn = 1'b1;
        sda_drv = 1'b1;
        i2c_stop();
        cpu_read("midrd_status", 24'h000040, status_exp());
        wq = '{8'h3C};
        i2c_write_txn(8'h07);
        check_all_regs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_target_regs.md
# i2c_target_regs

Soft-logic I2C target (responder) with a 16-byte register file, the far end of the bus driven by the SoC's I2C controller. An external or on-board I2C controller reads and writes the register file over SCL/SDA. The CPU reads and writes the same bytes through the native valid/ready memory bus. It sits beside the hard-IP wrapper in the peripheral address space, and the decode select arrives already qualified in `valid`.

## Interface
Parameters:
- `TARGET_ADDR`, 7'h42, 7-bit I2C target address.
- `SYNC_STAGES`, 2, synchronizer depth on SCL/SDA inputs (≥2).

Ports:
- `clock`  in  1  system clock, ≥16× SCL frequency.
- `resetn`  in  1  reset; one clock, asynchronous and active-low.
- `address`  in  24  CPU byte address; only bits [6:2] are used.
- `write_data`  in  32  CPU write data; bits [7:0] are used.
- `read_data`  out  32  CPU read data, registered, zero-extended byte.
- `wstrb`  in  4  write strobes; write if `wstrb[0]`, else read.
- `valid`  in  1  CPU request, already address-decoded.
- `ready`  out  1  one-cycle acknowledge.
- `scl_i`  in  1  SCL pin input. Asynchronous.
- `sda_i`  in  1  SDA pin input. Asynchronous.
- `sda_oe`  out  1  high = pull SDA low (open drain, external SB_IO).
- `irq`  out  1  level interrupt; equals `status.wr_event`.

## Operation
- CPU map, decoded on `address[6:2]`:
  - 0x00–0x0F: register file byte `address[5:2]`.
  - 0x10: status. bit0 `busy` (RO), bit1 `wr_event`, bit2 `collision`. Bits 1 and 2 are write-1-to-clear.
  - Other offsets read 0 and ignore writes.
- CPU handshake: when `valid && !ready`, the access completes in that cycle. `ready` is high for exactly the next cycle. `ready` is 0 whenever `valid` is 0.
- SCL/SDA pass through `SYNC_STAGES` flops and then an edge detector.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Repeated START is accepted in any state.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - START → ADDR, bit counter = 0. STOP in any state → IDLE.
  - ADDR: shift 8 bits MSB-first on SCL rise. On match of [7:1] == `TARGET_ADDR`, go to ADDR_ACK. On mismatch, go to IGNORE and do not ACK.
  - ADDR_ACK: drive ACK.
    - R/W=0 → PTR.
    - R/W=1 → RDATA, loading `regs[ptr]` into the shift register.
  - PTR: receive 8 bits, `ptr <= byte[3:0]` (upper nibble ignored), ACK → WDATA.
  - WDATA: receive a byte, write `regs[ptr]`, `ptr++` (mod 16), set `wr_event`, ACK, stay in WDATA.
  - RDATA: shift out MSB-first. In RDATA_ACK, sample the controller's ACK on SCL rise.
    - ACK (SDA=0): `ptr++`, load the next byte, → RDATA.
    - NACK: → IGNORE until STOP/START. `ptr++` still applies.
- SDA drive: `sda_oe` changes only on a detected SCL fall. For ACK it is asserted on the fall after bit 8 and released on the following fall. For read data, `sda_oe = ~bit`.
- `busy` = state ∉ {IDLE, IGNORE}.
- Simultaneous CPU write and I2C write to the same byte in the same cycle: the I2C write wins, the CPU write is dropped, and `collision` is set. CPU `ready` still pulses.
- Pointer wraps 15 → 0 on both write and read.

## Timing
- Reset values: `read_data`=0, `ready`=0, `sda_oe`=0, `irq`=0. FSM=IDLE, `ptr`=0, status=0, register file=0.
- Assertion of `resetn` is asynchronous. Reset mid-transfer releases SDA immediately, and no partial byte is written.
- CPU latency: 1 cycle from `valid` to `ready`; `read_data` is valid while `ready`=1.
- I2C timing:
  - Input latency is `SYNC_STAGES`+1 clocks from pin to edge event.
  - `sda_oe` updates 1 clock after the detected SCL fall, well within the tHD;DAT minimum.
  - A register write commits on the detected SCL rise of bit 8.
  - `wr_event` and `irq` rise in the following cycle.
- A read byte is latched at the ADDR_ACK→RDATA or RDATA_ACK→RDATA transition. A CPU write after that point is not reflected until the next byte.

## Test plan
- Reset → all outputs 0. CPU read of 0x10 returns 0. CPU read of 0x00 returns 0.
- I2C write: START, 0x84, 0x0E, 0xAA, 0xBB, STOP.
  - Expect target ACKs on all 4 bytes.
  - `regs[14]`=0xAA and `regs[15]`=0xBB.
  - ptr wraps to 0.
  - `irq`=1. CPU read of 0x38 returns 0xAA.
  - CPU write 0x2 to 0x10 clears `irq`.
- Repeated-START read:
  - CPU writes 0x5A to `regs[3]` and 0xC3 to `regs[4]`.
  - I2C sequence: START, 0x84, 0x03, Sr, 0x85, read with ACK, read with NACK, STOP.
  - Expect data 0x5A then 0xC3, and `busy`=0 after STOP.
- Address mismatch: START, 0x90, … → `sda_oe` never asserts and registers are unchanged.
- Collision: force an I2C write of 0x11 and a CPU write of 0x22 to `regs[2]` in the same cycle → `regs[2]`=0x11, `collision`=1, and `ready` pulses once.
- Reset mid-read: assert `resetn`=0 while `sda_oe`=1 → `sda_oe`=0 in the same cycle. After release, the FSM is IDLE and the next START transfer succeeds.
